// File: rtl/spi_master_driver.sv
// spi_master_driver: single-lane SPI master turning 10-bit RAM commands into SS_n/MOSI frames,
// capturing the 8-bit MISO reply of read-data commands.
module spi_master_driver #(
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, TURN, CAPTURE, GAP} state_t;
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 2);
    // The IDLE cycle that accepts the next command is itself one of the SS_n-high gap cycles,
    // so GAP only holds the remaining GAP_CYCLES-1 and is skipped entirely when that is zero.
    localparam state_t POST = (GAP_CYCLES > 1) ? GAP : IDLE;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [9:0] sh, sh_nxt;
    logic [6:0] cap, cap_nxt;
    logic       is_read, is_read_nxt;
    logic       rsp_fire, ss_nxt, mosi_nxt;
    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sh_nxt      = sh;
        cap_nxt     = cap;
        is_read_nxt = is_read;
        rsp_fire    = 1'b0;
        mosi_nxt    = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                state_nxt   = SELECT;
                cnt_nxt     = '0;
                sh_nxt      = cmd_data;
                cap_nxt     = '0;
                is_read_nxt = (cmd_data[9:8] == 2'b11);
                mosi_nxt    = cmd_data[9];
            end
            SELECT: begin
                state_nxt = SHIFT;
                cnt_nxt   = '0;
                mosi_nxt  = sh[9];
            end
            SHIFT: if (cnt == 4'd9) begin
                state_nxt = is_read ? TURN : POST;
                cnt_nxt   = '0;
                sh_nxt    = '0;
            end else begin
                cnt_nxt  = cnt + 4'd1;
                sh_nxt   = {sh[8:0], 1'b0};
                mosi_nxt = sh[8];
            end
            TURN: begin
                state_nxt = (cnt == TURN_LAST) ? CAPTURE : TURN;
                cnt_nxt   = (cnt == TURN_LAST) ? 4'd0 : cnt + 4'd1;
            end
            CAPTURE: begin
                cap_nxt   = {cap[5:0], MISO};
                rsp_fire  = (cnt == 4'd7);
                state_nxt = rsp_fire ? POST : CAPTURE;
                cnt_nxt   = rsp_fire ? 4'd0 : cnt + 4'd1;
            end
            GAP: begin
                state_nxt = (cnt == GAP_LAST) ? IDLE : GAP;
                cnt_nxt   = (cnt == GAP_LAST) ? 4'd0 : cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
        ss_nxt = (state_nxt == IDLE) || (state_nxt == GAP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            cap       <= '0;
            is_read   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sh        <= sh_nxt;
            cap       <= cap_nxt;
            is_read   <= is_read_nxt;
            rsp_valid <= rsp_fire;
            SS_n      <= ss_nxt;
            MOSI      <= mosi_nxt;
            if (rsp_fire) rsp_data <= {cap, MISO};
        end
    end
endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver: three spi_master_driver configurations checked every cycle against
// a frame-timeline model plus a RAM-wrapper model that answers read-data frames on MISO.
module tb_spi_master_driver;
    localparam int TC [3] = '{2, 1, 4};
    localparam int GC [3] = '{1, 1, 3};
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cmd_valid = '0;
    logic [2:0] miso = '0;
    logic [2:0] cmd_ready, rsp_valid, busy, ss_n, mosi;
    logic [9:0] cmd_data [3] = '{default: '0};
    logic [7:0] rsp_data [3];
    int tests = 0, fails = 0, cyc = 0, mk;
    bit         act [3];
    int         n [3], ln [3], acc [3], acc_cyc [3];
    logic [9:0] mc [3];
    logic [7:0] rexp [3], rbyte [3], maddr [3];
    logic [7:0] mem [3][256];

    always #5 clk = ~clk;

    spi_master_driver #(.TURN_CYCLES(2), .GAP_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .busy(busy[0]),
        .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]));
    spi_master_driver #(.TURN_CYCLES(1), .GAP_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .busy(busy[1]),
        .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]));
    spi_master_driver #(.TURN_CYCLES(4), .GAP_CYCLES(3)) u2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_data(cmd_data[2]), .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .busy(busy[2]),
        .SS_n(ss_n[2]), .MOSI(mosi[2]), .MISO(miso[2]));

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s dut%0d at cycle %0d: got %0h, expected %0h", nm, i, cyc, a, e);
        end
    endtask

    // Timeline of a frame in cycles after its accept edge: frame length ln, then GC-1 extra gap cycles.
    function automatic bit e_busy(input int i);
        return act[i] && (n[i] < ln[i] + GC[i] - 1);
    endfunction
    function automatic bit e_ss(input int i);
        return !(act[i] && n[i] < ln[i]);
    endfunction
    function automatic bit e_rv(input int i);
        return act[i] && mc[i][9:8] == 2'b11 && n[i] == ln[i];
    endfunction
    function automatic bit e_mosi(input int i);
        if (!act[i] || n[i] > 10) return 1'b0;
        if (n[i] == 0) return mc[i][9];
        return mc[i][10 - n[i]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                act[i]  = 1'b0;
                rexp[i] = '0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (!e_busy(i) && cmd_valid[i]) begin
                    act[i] = 1'b1;
                    n[i] = 0;
                    mc[i] = cmd_data[i];
                    ln[i] = (cmd_data[i][9:8] == 2'b11) ? 19 + TC[i] : 11;
                    acc[i]++;
                    acc_cyc[i] = cyc;
                    case (cmd_data[i][9:8])
                        2'b01:   mem[i][maddr[i]] = cmd_data[i][7:0];
                        2'b11:   rbyte[i] = mem[i][maddr[i]];
                        default: maddr[i] = cmd_data[i][7:0];
                    endcase
                end else if (act[i]) n[i]++;
                if (e_rv(i)) rexp[i] = rbyte[i];
            end
        end
    end

    // Wrapper side: present the addressed byte MSB first on the edges the master samples, noise elsewhere.
    always @(negedge clk)
        for (int i = 0; i < 3; i++) begin
            mk = n[i] + 1 - (12 + TC[i]);
            miso[i] = (act[i] && mc[i][9:8] == 2'b11 && mk >= 0 && mk < 8) ? rbyte[i][7 - mk] : 1'($urandom);
        end

    always @(negedge clk)
        for (int i = 0; i < 3; i++) begin
            chk("ss_n", i, 32'(ss_n[i]), 32'(e_ss(i)));
            chk("mosi", i, 32'(mosi[i]), 32'(e_mosi(i)));
            chk("busy", i, 32'(busy[i]), 32'(e_busy(i)));
            chk("cmd_ready", i, 32'(cmd_ready[i]), 32'(!e_busy(i)));
            chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(e_rv(i)));
            chk("rsp_data", i, 32'(rsp_data[i]), 32'(rexp[i]));
        end

    task automatic send(input int i, input logic [9:0] c);
        int a = acc[i];
        bit ok = 1'b0;
        cmd_valid[i] = 1'b1;
        cmd_data[i] = c;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = (acc[i] != a);
        end
        cmd_valid[i] = 1'b0;
        cmd_data[i] = 10'($urandom);
        if (!ok) chk("accept_timeout", i, 0, 1);
    endtask

    task automatic wait_idle(input int i);
        for (int t = 0; t < 100 && e_busy(i); t++) @(negedge clk);
        if (e_busy(i)) chk("idle_timeout", i, 1, 0);
    endtask

    task automatic wait_rsp(input int i, output int lat);
        lat = -1;
        for (int t = 0; t < 80; t++) begin
            if (rsp_valid[i]) begin
                lat = cyc - acc_cyc[i];
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk("rsp_timeout", i, 0, 1);
    endtask

    task automatic rnd(input int i);
        logic [9:0] c;
        for (int j = 0; j < 30; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            c = 10'($urandom);
            c[7:3] = '0;
            send(i, c);
        end
        wait_idle(i);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, lat1, lat4, a, hi, k;
        int t [3];
        logic [10:0] bits;
        logic [9:0] bb [3];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 256; j++) mem[i][j] = 8'($urandom);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", i, 32'(cmd_ready[i]), 1);
            chk("rst_busy", i, 32'(busy[i]), 0);
            chk("rst_ss_n", i, 32'(ss_n[i]), 1);
            chk("rst_rsp_data", i, 32'(rsp_data[i]), 0);
        end
        // Write-address frame: MOSI pattern and the single high gap cycle.
        send(0, 10'b00_1010_0101);
        bits = '0;
        for (int j = 0; j < 11; j++) begin
            bits = {bits[9:0], mosi[0]};
            @(negedge clk);
        end
        chk("wa_mosi_seq", 0, 32'(bits), 32'b000_1010_0101);
        chk("wa_ss_high", 0, 32'(ss_n[0]), 1);
        wait_idle(0);
        // Write 0xA7 to 0x3C, read it back.
        send(0, 10'h03C);
        send(0, 10'h1A7);
        send(0, 10'h23C);
        send(0, 10'h300);
        wait_rsp(0, lat);
        chk("wr_rd_latency", 0, 32'(lat), 21);
        chk("wr_rd_data", 0, 32'(rsp_data[0]), 32'h A7);
        wait_idle(0);
        // Back-to-back with cmd_valid held.
        bb = '{10'h011, 10'h122, 10'h033};
        cmd_valid[0] = 1'b1;
        cmd_data[0] = bb[0];
        a = acc[0];
        k = 0;
        hi = 0;
        for (int j = 0; j < 100 && k < 3; j++) begin
            @(negedge clk);
            if (acc[0] != a) begin
                t[k] = acc_cyc[0];
                a = acc[0];
                k++;
                if (k < 3) cmd_data[0] = bb[k];
            end else if (k > 0 && ss_n[0]) hi++;
        end
        cmd_valid[0] = 1'b0;
        chk("b2b_accepts", 0, 32'(k), 3);
        chk("b2b_space1", 0, 32'(t[1] - t[0]), 12);
        chk("b2b_space2", 0, 32'(t[2] - t[1]), 12);
        chk("b2b_gap_cycles", 0, 32'(hi), 2);
        wait_idle(0);
        // Restore address 0x3C, then pulse a command during CAPTURE of a read.
        send(0, 10'h23C);
        send(0, 10'h300);
        for (int j = 0; j < 40 && n[0] != 15; j++) @(negedge clk);
        a = acc[0];
        chk("drop_ready", 0, 32'(cmd_ready[0]), 0);
        cmd_valid[0] = 1'b1;
        cmd_data[0] = 10'h055;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        wait_idle(0);
        chk("drop_no_accept", 0, 32'(acc[0]), 32'(a));
        chk("drop_rsp_data", 0, 32'(rsp_data[0]), 32'hA7);
        // Turnaround sweep on TURN_CYCLES=1 and 4.
        fork
            begin send(1, 10'h011); send(1, 10'h15A); send(1, 10'h211); send(1, 10'h300); wait_rsp(1, lat1); end
            begin send(2, 10'h011); send(2, 10'h15A); send(2, 10'h211); send(2, 10'h300); wait_rsp(2, lat4); end
        join
        chk("sweep_data_t1", 1, 32'(rsp_data[1]), 32'h5A);
        chk("sweep_data_t4", 2, 32'(rsp_data[2]), 32'h5A);
        chk("sweep_lat_t1", 1, 32'(lat1), 20);
        chk("sweep_lat_shift", 2, 32'(lat4 - lat1), 3);
        wait_idle(1);
        wait_idle(2);
        // Asynchronous reset in the middle of SHIFT.
        send(0, 10'h1FF);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ss_n", 0, 32'(ss_n[0]), 1);
        chk("rst_async_mosi", 0, 32'(mosi[0]), 0);
        chk("rst_async_rsp", 0, 32'(rsp_data[0]), 0);
        chk("rst_async_ready", 0, 32'(cmd_ready[0]), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 0, 32'(cmd_ready[0]), 1);
        fork
            rnd(0);
            rnd(1);
            rnd(2);
        join
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
